btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_pkg.sv | 30 +++
 rtl/btn_conditioner_if.sv | 44 ++++
 rtl/btn_debounce_ch.sv | 174 +++++++++++++++++
 rtl/btn_conditioner.sv | 58 +++++
 tb/tb_btn_conditioner.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg -- shared definitions for the pushbutton conditioner.
//
// Contents:
//   btn_state_t               per-channel debounce FSM state
//   DEFAULT_NUM_BTN           default channel count (left, right, on_off, up, down)
//   DEFAULT_DEBOUNCE_CYCLES   20 ms at 100 MHz
//   DEFAULT_LONG_PRESS_CYCLES 3 s at 100 MHz
//   cnt_width()               counter width able to hold 0..n inclusive
// ---------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_DB_RELEASE = 2'd3
    } btn_state_t;

    localparam int unsigned DEFAULT_NUM_BTN           = 32'd5;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 32'd2_000_000;
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 32'd300_000_000;

    // One spare bit above $clog2 so the terminal value itself is
    // representable and the counters never need to wrap.
    function automatic int cnt_width(input int unsigned n);
        return $clog2(n) + 32'sd1;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// ---------------------------------------------------------------------------
// btn_conditioner_if -- bundle of the raw button inputs and the conditioned
// event outputs of btn_conditioner.
//
// Signals (all NUM_BTN wide, one bit per channel):
//   btn_raw      raw asynchronous pushbutton levels, 1 = pressed
//   btn_level    debounced level
//   btn_press    1-cycle pulse on each accepted press
//   btn_release  1-cycle pulse on each accepted release
//   btn_long     1-cycle pulse when a press has been held long enough
//
// Modports:
//   master  drives btn_raw, observes the conditioned outputs
//   slave   the conditioner itself
// ---------------------------------------------------------------------------
interface btn_conditioner_if
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN = DEFAULT_NUM_BTN
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );

endinterface

// File: rtl/btn_debounce_ch.sv
// ---------------------------------------------------------------------------
// btn_debounce_ch -- one pushbutton channel: 2-flop synchronizer, 4-state
// debounce FSM and (optionally) a long-press detector.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   raw_i      raw asynchronous button level, 1 = pressed
//   level_o    debounced level
//   press_o    1-cycle pulse on an accepted press
//   release_o  1-cycle pulse on an accepted release
//   long_o     1-cycle pulse once a press has been held LONG_PRESS_CYCLES
//
// Build option:
//   BTN_LONG_PRESS_EN  when defined, the held-cycle counter and long_o pulse
//                      are built; otherwise long_o is tied to 0.
// ---------------------------------------------------------------------------
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    // The level is accepted in the cycle the counter shows DEBOUNCE_CYCLES-1,
    // so the counter never has to reach DEBOUNCE_CYCLES itself.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 32'd1);

    logic       sync1_q;
    logic       sync2_q;
    logic       sync_s;

    btn_state_t      state_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            level_q;
    logic            press_q;
    logic            release_q;

    logic            press_evt_s;
    logic            release_evt_s;

    // Two-flop synchronizer bringing the asynchronous button into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign sync_s = sync2_q;

    // A change is accepted when the new level has been seen on the final
    // debounce cycle; shared by the FSM and the long-press counter.
    assign press_evt_s   = (state_q == ST_DB_PRESS)   &&  sync_s && (db_cnt_q == DB_LAST);
    assign release_evt_s = (state_q == ST_DB_RELEASE) && !sync_s && (db_cnt_q == DB_LAST);

    // Debounce FSM with registered level and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            db_cnt_q  <= DB_W'(0);
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sync_s) begin
                        state_q  <= ST_DB_PRESS;
                        db_cnt_q <= DB_W'(0);
                    end
                end
                ST_DB_PRESS: begin
                    if (!sync_s) begin
                        state_q <= ST_IDLE;
                    end else if (press_evt_s) begin
                        state_q <= ST_PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!sync_s) begin
                        state_q  <= ST_DB_RELEASE;
                        db_cnt_q <= DB_W'(0);
                    end
                end
                ST_DB_RELEASE: begin
                    if (sync_s) begin
                        state_q <= ST_PRESSED;
                    end else if (release_evt_s) begin
                        state_q   <= ST_IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    db_cnt_q <= DB_W'(0);
                    level_q  <= 1'b0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int LP_W = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 32'd1);

    logic [LP_W-1:0] hold_q;
    logic [LP_W-1:0] hold_d;
    logic            long_q;
    logic            long_d;
    logic            held_s;

    // The button counts as held until the release is accepted, so a
    // bounce on release still advances the held-cycle count.
    assign held_s = (state_q == ST_PRESSED) || (state_q == ST_DB_RELEASE);

    // Held-cycle counter: restarts on the press edge, saturates at the
    // threshold so the long pulse fires only once per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_evt_s) begin
            hold_d = LP_W'(0);
        end else if (held_s && (hold_q != LP_MAX)) begin
            hold_d = hold_q + LP_W'(1);
            long_d = (hold_q == LP_LAST);
        end else begin
            hold_d = hold_q;
        end
    end

    // Held-cycle counter and long-press pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= LP_W'(0);
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner -- debounces NUM_BTN independent pushbuttons and produces
// level, press, release and long-press indications per channel.
//
// Parameters:
//   NUM_BTN            number of channels
//   DEBOUNCE_CYCLES    consecutive stable cycles needed to accept a change
//   LONG_PRESS_CYCLES  held cycles after the accepted press before btn_long
//
// Ports:
//   clk   system clock (100 MHz), the only clock
//   rst   synchronous active-high reset
//   bus   btn_conditioner_if.slave: btn_raw in; btn_level, btn_press,
//         btn_release, btn_long out
//
// Build option:
//   BTN_LONG_PRESS_EN  enables the long-press detector; without it btn_long
//                      is constant 0.
// ---------------------------------------------------------------------------
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN           = DEFAULT_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    btn_conditioner_if.slave   bus
);

    logic [NUM_BTN-1:0] level_s;
    logic [NUM_BTN-1:0] press_s;
    logic [NUM_BTN-1:0] release_s;
    logic [NUM_BTN-1:0] long_s;

    // One fully independent conditioner per button.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .raw_i     (bus.btn_raw[g]),
            .level_o   (level_s[g]),
            .press_o   (press_s[g]),
            .release_o (release_s[g]),
            .long_o    (long_s[g])
        );
    end

    assign bus.btn_level   = level_s;
    assign bus.btn_press   = press_s;
    assign bus.btn_release = release_s;
    assign bus.btn_long    = long_s;

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner -- self-checking bench for btn_conditioner with
// DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=10.  A reference model counts
// consecutive samples that disagree with the accepted level; it is compared
// with the DUT every cycle, and directed scenarios check event latencies.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int LP = 10;
`ifdef BTN_LONG_PRESS_EN
    localparam int LONG_EN = 1;
`else
    localparam int LONG_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] raw_v;

    always #5 clk = ~clk;

    btn_conditioner_if #(.NUM_BTN(NB)) bus ();
    assign bus.btn_raw = raw_v;

    btn_conditioner #(
        .NUM_BTN           (NB),
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    logic [NB-1:0] m_p1, m_p2;        // raw delayed by one and two samples
    logic [NB-1:0] m_lvl, m_press, m_rel, m_long;
    int            m_run  [NB];
    int            m_held [NB];

    // observed event statistics
    int press_cnt [NB], rel_cnt [NB], long_cnt [NB];
    int last_press[NB], last_rel[NB], last_long[NB];
    int watch_cyc = -1;
    logic [NB-1:0] watch_press;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model: a level change is accepted after DB+1 consecutive disagreeing
    // synchronized samples; the long pulse fires when the button has been
    // accepted-held for LP edges after the press.
    task automatic model_edge();
        m_press = '0; m_rel = '0; m_long = '0;
        if (rst) begin
            m_p1 = '0; m_p2 = '0; m_lvl = '0;
            for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_held[c] = 0; end
        end else begin
            for (int c = 0; c < NB; c++) begin
                if (m_lvl[c] && m_held[c] < LP) begin
                    m_held[c]++;
                    if (m_held[c] == LP && LONG_EN != 0) m_long[c] = 1'b1;
                end
                if (m_p2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB + 1) begin
                        m_lvl[c] = m_p2[c];
                        m_run[c] = 0;
                        if (m_lvl[c]) begin m_press[c] = 1'b1; m_held[c] = 0; end
                        else m_rel[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_p2 = m_p1;
            m_p1 = raw_v;
        end
    endtask

    task automatic clear_stats();
        for (int c = 0; c < NB; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
            last_press[c] = -1; last_rel[c] = -1; last_long[c] = -1;
        end
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_val("level",   32'(bus.btn_level),   32'(m_lvl));
        check_val("press",   32'(bus.btn_press),   32'(m_press));
        check_val("release", 32'(bus.btn_release), 32'(m_rel));
        check_val("long",    32'(bus.btn_long),    32'(m_long));
        check_val("excl",    32'(|(bus.btn_press & bus.btn_release)), 32'd0);
        for (int c = 0; c < NB; c++) begin
            if (bus.btn_press[c])   begin press_cnt[c]++; last_press[c] = cyc; end
            if (bus.btn_release[c]) begin rel_cnt[c]++;   last_rel[c]   = cyc; end
            if (bus.btn_long[c])    begin long_cnt[c]++;  last_long[c]  = cyc; end
        end
        if (cyc == watch_cyc) watch_press = bus.btn_press;
    endtask

    task automatic do_reset();
        rst = 1'b1; raw_v = '0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        clear_stats();
    endtask

    int e0, hold_left[NB];

    initial begin
        rst = 1'b1; raw_v = '0;
        for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_held[c] = 0; hold_left[c] = 0; end
        m_p1 = '0; m_p2 = '0; m_lvl = '0;
        clear_stats();
        @(negedge clk);
        tick();
        check_val("rst_level", 32'(bus.btn_level), 32'd0);
        check_val("rst_press", 32'(bus.btn_press), 32'd0);
        check_val("rst_long",  32'(bus.btn_long),  32'd0);
        do_reset();

        // clean press, long press, release on channel 0
        raw_v[0] = 1'b1; e0 = cyc + 1;
        repeat (20) tick();
        check_val("clean_press_cnt", 32'(press_cnt[0]), 32'd1);
        check_val("clean_press_lat", 32'(last_press[0] - e0), 32'd6);
        check_val("clean_level", 32'(bus.btn_level[0]), 32'd1);
        check_val("long_cnt", 32'(long_cnt[0]), 32'(LONG_EN));
`ifdef BTN_LONG_PRESS_EN
        check_val("long_lat", 32'(last_long[0] - last_press[0]), 32'd10);
`endif
        raw_v[0] = 1'b0; e0 = cyc + 1;
        repeat (12) tick();
        check_val("rel_cnt", 32'(rel_cnt[0]), 32'd1);
        check_val("rel_lat", 32'(last_rel[0] - e0), 32'd6);
        check_val("rel_level", 32'(bus.btn_level[0]), 32'd0);
        check_val("long_once", 32'(long_cnt[0]), 32'(LONG_EN));

        // bounce then steady press on channel 2, then a short glitch
        do_reset();
        raw_v[2] = 1'b1; tick();
        raw_v[2] = 1'b0; tick();
        raw_v[2] = 1'b1; tick();
        raw_v[2] = 1'b0; tick();
        raw_v[2] = 1'b1; e0 = cyc + 1;
        repeat (15) tick();
        check_val("bounce_cnt", 32'(press_cnt[2]), 32'd1);
        check_val("bounce_lat", 32'(last_press[2] - e0), 32'd6);
        raw_v[2] = 1'b0; tick(); tick();
        raw_v[2] = 1'b1;
        repeat (12) tick();
        check_val("glitch_rel", 32'(rel_cnt[2]), 32'd0);
        check_val("glitch_level", 32'(bus.btn_level[2]), 32'd1);

        // reset while held: outputs clear, no release, re-press after reset
        rst = 1'b1;
        tick();
        check_val("midrst_level", 32'(bus.btn_level), 32'd0);
        check_val("midrst_press", 32'(bus.btn_press | bus.btn_release), 32'd0);
        rst = 1'b0; clear_stats(); e0 = cyc + 1;
        repeat (12) tick();
        check_val("midrst_rel", 32'(rel_cnt[2]), 32'd0);
        check_val("midrst_repress", 32'(press_cnt[2]), 32'd1);
        check_val("midrst_lat", 32'(last_press[2] - e0), 32'd6);

        // simultaneous press on channels 0 and 1
        do_reset();
        raw_v[1:0] = 2'b11; e0 = cyc + 1;
        watch_cyc = e0 + 6; watch_press = '0;
        repeat (10) tick();
        check_val("simul", 32'(watch_press[1:0]), 32'd3);

        // randomized activity on all channels with rare resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (hold_left[c] == 0) begin
                    raw_v[c] = ~raw_v[c];
                    hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                               : int'($urandom_range(5, 30));
                end else begin
                    hold_left[c]--;
                end
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
